// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the execute-stage ALU and the data
// memory port. It captures one load or store, runs a req/ready handshake,
// builds byte enables and lane-replicated write data, and returns a
// one-cycle write-back with the aligned, sign/zero-extended load result.
// While an access is outstanding the upstream stage is stalled.
//
// Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned half/word
// requests with a one-cycle misalign pulse instead of issuing them. Without
// it, misalign is constant 0 and the offending low address bits are cleared
// so the access proceeds aligned.
module lsu_ctrl #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic            st_en,
    input  logic [2:0]      f3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] st_data,
    input  logic [RD_W-1:0] rd_in,
    output logic            stall,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_en,
    output logic [RD_W-1:0] wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misalign
);

    // FSM encoding
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_WB     = 2'b10;

    // Access size encoding in f3[1:0]; 2'b11 falls through to word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    localparam int NLANE = 4;

    // ------------------------------------------------------------------
    // State and captured request
    // ------------------------------------------------------------------
    logic [1:0]      state_q,     state_d;
    logic            mem_req_q,   mem_req_d;
    logic            mem_we_q,    mem_we_d;
    logic [XLEN-1:0] mem_addr_q,  mem_addr_d;
    logic [3:0]      mem_be_q,    mem_be_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]      f3_q,        f3_d;
    logic [1:0]      lane_q,      lane_d;
    logic [RD_W-1:0] rd_q,        rd_d;
    logic            wb_en_q,     wb_en_d;
    logic [RD_W-1:0] wb_rd_q,     wb_rd_d;
    logic [XLEN-1:0] wb_data_q,   wb_data_d;
    logic            misalign_q,  misalign_d;

    // ------------------------------------------------------------------
    // Request decode (combinational, from the upstream inputs)
    // ------------------------------------------------------------------
    logic [1:0]      req_size;
    logic            req_is_half;
    logic            req_is_word;
    logic            req_misaligned;
    logic [1:0]      req_off;
    logic [3:0]      req_be;
    logic [XLEN-1:0] req_wdata;
    logic            accept;
    logic            issue;
    logic            trap_pulse;

    assign req_size       = f3[1:0];
    assign req_is_half    = (req_size == SZ_HALF);
    assign req_is_word    = req_size[1];
    assign req_misaligned = (req_is_half & addr[0])
                          | (req_is_word & (addr[1:0] != 2'b00));

    // A new request can be taken whenever no access is in flight; the WB
    // cycle counts as free so back-to-back accesses have no idle gap.
    assign accept = ((state_q == ST_IDLE) | (state_q == ST_WB)) & (ld_en | st_en);

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned requests are swallowed: flagged, never issued.
    assign req_off    = addr[1:0];
    assign issue      = accept & ~req_misaligned;
    assign trap_pulse = accept & req_misaligned;
`else
    // Misaligned requests are forced onto their natural boundary.
    assign req_off    = req_misaligned ? (req_is_word ? 2'b00 : {addr[1], 1'b0})
                                       : addr[1:0];
    assign issue      = accept;
    assign trap_pulse = 1'b0;
`endif

    // Byte enables for the requested size and lane
    always_comb begin
        if (req_is_word) begin
            req_be = 4'b1111;
        end else if (req_is_half) begin
            req_be = 4'b0011 << {req_off[1], 1'b0};
        end else begin
            req_be = 4'b0001 << req_off;
        end
    end

    // Write data replication: every lane carries the byte the memory will
    // pick up under the enables, so no shifting is needed per address.
    genvar gi;
    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_wlane
            assign req_wdata[8*gi +: 8] =
                req_is_word ? st_data[8*gi +: 8] :
                req_is_half ? st_data[8*(gi % 2) +: 8] :
                              st_data[7:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Load alignment and extension (from the captured request)
    // ------------------------------------------------------------------
    logic [7:0]      rd_lane [NLANE];
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_ext;

    generate
        for (gi = 0; gi < NLANE; gi++) begin : g_rlane
            assign rd_lane[gi] = mem_rdata[8*gi +: 8];
        end
    endgenerate

    // Pick the addressed lane(s) and sign- or zero-extend per f3[2]
    always_comb begin
        ld_byte = rd_lane[lane_q];
        ld_half = {rd_lane[{lane_q[1], 1'b1}], rd_lane[{lane_q[1], 1'b0}]};
        case (f3_q[1:0])
            SZ_BYTE: ld_ext = f3_q[2] ? {{(XLEN-8){1'b0}}, ld_byte}
                                      : {{(XLEN-8){ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = f3_q[2] ? {{(XLEN-16){1'b0}}, ld_half}
                                      : {{(XLEN-16){ld_half[15]}}, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // Sequencer: accept/issue in IDLE or WB, wait for mem_ready in ACCESS
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        f3_d        = f3_q;
        lane_d      = lane_q;
        rd_d        = rd_q;
        wb_en_d     = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        misalign_d  = trap_pulse;

        case (state_q)
            ST_ACCESS: begin
                // Everything on the memory side is held until the handshake
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_WB;
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = ld_ext;
                    end
                end
            end
            default: begin
                // IDLE and WB both fall back to IDLE unless a request issues
                state_d = ST_IDLE;
                if (issue) begin
                    state_d     = ST_ACCESS;
                    mem_req_d   = 1'b1;
                    mem_we_d    = st_en & ~ld_en;
                    mem_addr_d  = {addr[XLEN-1:2], 2'b00};
                    mem_be_d    = req_be;
                    mem_wdata_d = req_wdata;
                    f3_d        = f3;
                    lane_d      = req_off;
                    rd_d        = rd_in;
                end
            end
        endcase
    end

    // State registers with synchronous reset; reset abandons any access
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            f3_q        <= '0;
            lane_q      <= '0;
            rd_q        <= '0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            f3_q        <= f3_d;
            lane_q      <= lane_d;
            rd_q        <= rd_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            misalign_q  <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // stall drops in the mem_ready cycle so upstream advances once per access
    assign stall     = accept | ((state_q == ST_ACCESS) & ~mem_ready);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign misalign  = misalign_q;

endmodule
